// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Provides the FSM state encoding and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// 1-bit full adder built from two half-adder stages plus an OR of their carries.
// Ports: a, b, cin in; s (sum), cout (carry out) out. Purely combinational.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // first half adder: a + b
    assign ha0_s = a ^ b;
    assign ha0_c = a & b;

    // second half adder: partial sum + cin
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;

    assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first through one full-adder cell.
// Ports: clk, rst (async, high); in_valid/in_ready + a, b in; out_valid/out_ready + sum, cout out; busy.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic fa_s;
    logic fa_co;

    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                // sum bits enter at the MSB; after WIDTH shifts bit i lands at index i
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                if (cnt_q == LAST) begin
                    cout_d  = fa_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Directed cases plus random operands checked against plain a+b arithmetic.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer operands, wait for the result and check it against a+b.
    // stall = cycles out_ready is held low once the result is valid.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input int stall);
        logic [W:0] ref_tot;
        logic [W-1:0] held_s;
        logic held_c;
        int lat;
        ref_tot = {1'b0, xa} + {1'b0, xb};
        out_ready = (stall == 0);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_in_run", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(W));
        chk("sum", 32'(sum), 32'(ref_tot[W-1:0]));
        chk("cout", 32'(cout), 32'(ref_tot[W]));
        held_s = sum;
        held_c = cout;
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'(ref_tot[W-1:0]));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("idle_after_done", 32'(in_ready), 32'd1);
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("sum_kept_idle", 32'({held_c, held_s}), 32'({cout, sum}));
    endtask

    initial begin
        logic [W:0] ref_tot;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;

        // reset then idle
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);

        // directed arithmetic
        do_op(8'h0F, 8'h01, 0);
        do_op(8'hFF, 8'h01, 0);
        do_op(8'hFF, 8'hFF, 0);
        do_op(8'h00, 8'h00, 0);

        // backpressure with in_valid held high in DONE
        out_ready = 1'b0;
        a = 8'h10;
        b = 8'h20;
        in_valid = 1'b1;
        step();
        a = 8'h55;
        b = 8'h22;
        repeat (W) step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_sum", 32'(sum), 32'h30);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", 32'({cout, sum}), 32'h030);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", 32'(in_ready), 32'd1);
        do_op(8'h55, 8'h22, 0);
        chk("bp_sum_77", 32'(sum), 32'h77);

        // reset mid-run discards the operation
        a = 8'hA5;
        b = 8'h5A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sum", 32'({cout, sum}), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            step();
            chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
        end
        do_op(8'h01, 8'h02, 0);
        chk("post_rst_sum", 32'(sum), 32'h03);

        // random operands and stalls
        for (int i = 0; i < 25; i++) begin
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end

        ref_tot = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
